ped_signal: RTL and testbench
=============================

PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 SHALL have parameter DebounceCycles, default 4, consecutive stable synchronized samples needed to accept a button level change.
REQ-002 SHALL have parameter WalkCycles, default 16, clock cycles walk is held high.
REQ-003 SHALL have parameter FlashCycles, default 8, clock cycles of the flashing-clearance phase.
REQ-004 SHALL have parameter FlashPeriod, default 2, cycles per dont_walk half-period during flashing.
REQ-005 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-006 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ped_btn  input  1  raw asynchronous pedestrian button, high = pressed.
REQ-008 SHALL have port rgb  input  3  vehicle light observed from the traffic-light controller; [2]=R, [1]=G, [0]=B; vehicle red is exactly 3'b100.
REQ-009 SHALL have port btn  output  1  crossing request to the traffic-light controller, level held until served.
REQ-010 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-011 SHALL have port dont_walk  output  1  pedestrian don't-walk lamp.
REQ-012 SHALL have port fault  output  1  sticky safety-abort flag.

Function
REQ-013 ped_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounced level SHALL change only after DebounceCycles consecutive synchronized samples differing from the current debounced level; any mismatching sample restarts the count.
REQ-015 A rising edge of the debounced level SHALL set pending; press-to-btn latency with stable input SHALL be DebounceCycles+3 clock edges.
REQ-016 Rising edges during WALK SHALL be ignored; in every other state they SHALL set pending.
REQ-017 btn SHALL equal pending; pending SHALL clear on the edge that enters WALK.
REQ-018 FSM states: IDLE, WAIT_RED, WALK, FLASH, CLEAR.
REQ-019 IDLE: walk=0, dont_walk=1; go to WAIT_RED on the edge after pending is 1.
REQ-020 WAIT_RED: walk=0, dont_walk=1; when rgb==3'b100 is sampled, enter WALK on that edge.
REQ-021 WALK: walk=1, dont_walk=0 for exactly WalkCycles cycles, then FLASH.
REQ-022 FLASH: walk=0; dont_walk=0 for the first FlashPeriod cycles, then toggles every FlashPeriod cycles; after exactly FlashCycles cycles, go to CLEAR.
REQ-023 CLEAR: walk=0, dont_walk=1; once rgb!=3'b100 is sampled, go to WAIT_RED if pending else IDLE.
REQ-024 Safety: rgb!=3'b100 sampled in WALK or FLASH SHALL, on that edge, force IDLE (dont_walk=1, walk=0 next cycle) and set fault; pending is kept.
REQ-025 walk and dont_walk SHALL never both be 1.
REQ-026 fault SHALL stay 1 until res.
REQ-027 Cycle counters SHALL be sized for max(WalkCycles, FlashCycles) without wrap; FSM and counters reload from zero on each state entry.
REQ-028 A button press and a WALK exit on the same edge SHALL set pending, because the press lands in FLASH.

Reset
REQ-029 While res is 1 at a clock edge: state IDLE, pending=0, fault=0, counters=0, synchronizer and debounced level=0.
REQ-030 Outputs after reset: btn=0, walk=0, dont_walk=1, fault=0.
REQ-031 res mid-WALK SHALL end walk on the next edge with no FLASH phase.

Verification
REQ-032 Basic cycle, defaults: rgb=3'b010, ped_btn high from cycle 0 -> btn=1 at edge 7; rgb=3'b100 -> walk=1 for 16 cycles, btn=0; dont_walk pattern 0,0,1,1,0,0,1,1; then CLEAR; IDLE after rgb returns to 3'b010.
REQ-033 Bounce: ped_btn toggles every 2 cycles for 20 cycles, then settles low -> btn stays 0.
REQ-034 Abort: rgb changes 3'b100->3'b110 at WALK cycle 5 -> walk=0, dont_walk=1 next cycle; fault=1 and stays 1.
REQ-035 Re-request: press during FLASH -> btn=1; after CLEAR with rgb!=3'b100, FSM enters WAIT_RED directly.
REQ-036 Press during WALK -> ignored; FSM returns to IDLE with btn=0.
REQ-037 Reset: res=1 at WALK cycle 3 -> next cycle walk=0, dont_walk=1, btn=0, fault=0.

Source files
------------

// File: rtl/ped_signal.sv
// Pedestrian crossing controller: synchronized/debounced button, walk/flash/clear sequencing, safety abort.
// Press-to-btn latency is DebounceCycles+3 edges; walk/dont_walk decode combinationally from state.
module ped_signal #(
  parameter int DebounceCycles = 4,
  parameter int WalkCycles     = 16,
  parameter int FlashCycles    = 8,
  parameter int FlashPeriod    = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ped_btn,
  input  logic [2:0] rgb,
  output logic       btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       fault
);

  localparam int MaxCycles = (WalkCycles > FlashCycles) ? WalkCycles : FlashCycles;
  localparam int CW = $clog2(MaxCycles + 1);
  localparam int DW = $clog2(DebounceCycles + 1);
  localparam int PW = $clog2(FlashPeriod + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RED, WALK, FLASH, CLEAR} state_t;

  state_t          state, state_n;
  logic            sync1, sync2;
  logic            db_lvl, db_lvl_d;
  logic [DW-1:0]   db_cnt;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   fp_cnt;
  logic            flash_dw;
  logic            pending;
  logic            fault_set;
  logic            veh_red;
  logic            rise;

  assign veh_red = (rgb == 3'b100);
  assign rise    = db_lvl & ~db_lvl_d;
  assign btn     = pending;

  always_comb begin
    state_n   = state;
    fault_set = 1'b0;
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state)
      IDLE: begin
        if (pending) state_n = WAIT_RED;
      end
      WAIT_RED: begin
        if (veh_red) state_n = WALK;
      end
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
        // Losing vehicle red overrides the normal timeout.
        if (!veh_red) begin
          state_n   = IDLE;
          fault_set = 1'b1;
        end else if (cnt == CW'(WalkCycles - 1)) begin
          state_n = FLASH;
        end
      end
      FLASH: begin
        dont_walk = flash_dw;
        if (!veh_red) begin
          state_n   = IDLE;
          fault_set = 1'b1;
        end else if (cnt == CW'(FlashCycles - 1)) begin
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        if (!veh_red) state_n = pending ? WAIT_RED : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_lvl   <= 1'b0;
      db_lvl_d <= 1'b0;
      db_cnt   <= '0;
      state    <= IDLE;
      cnt      <= '0;
      fp_cnt   <= '0;
      flash_dw <= 1'b0;
      pending  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      sync1    <= ped_btn;
      sync2    <= sync1;
      db_lvl_d <= db_lvl;

      if (sync2 != db_lvl) begin
        if (db_cnt == DW'(DebounceCycles - 1)) begin
          db_lvl <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end

      state <= state_n;
      if (state_n != state) begin
        cnt      <= '0;
        fp_cnt   <= '0;
        flash_dw <= 1'b0;
      end else begin
        if (state == WALK || state == FLASH) cnt <= cnt + CW'(1);
        if (state == FLASH) begin
          if (fp_cnt == PW'(FlashPeriod - 1)) begin
            fp_cnt   <= '0;
            flash_dw <= ~flash_dw;
          end else begin
            fp_cnt <= fp_cnt + PW'(1);
          end
        end
      end

      // A press is ignored only if the FSM stays in WALK; entering WALK serves the request.
      if (state != WALK && state_n == WALK)
        pending <= 1'b0;
      else if (rise && state_n != WALK)
        pending <= 1'b1;

      if (fault_set) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ped_signal.sv
module tb_ped_signal;

  logic       clk;
  logic       res;
  logic       ped_btn;
  logic [2:0] rgb;
  logic       btn;
  logic       walk;
  logic       dont_walk;
  logic       fault;

  int checks = 0;
  int errors = 0;

  ped_signal dut (
    .clk       (clk),
    .res       (res),
    .ped_btn   (ped_btn),
    .rgb       (rgb),
    .btn       (btn),
    .walk      (walk),
    .dont_walk (dont_walk),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_btn, input logic e_walk,
                            input logic e_dw, input logic e_fault);
    check({tag, ".btn"}, btn, e_btn);
    check({tag, ".walk"}, walk, e_walk);
    check({tag, ".dont_walk"}, dont_walk, e_dw);
    check({tag, ".fault"}, fault, e_fault);
  endtask

  logic [7:0] flash_pat;

  initial begin
    flash_pat = 8'b1100_1100; // index 0 is the first FLASH cycle
    res = 1'b1;
    ped_btn = 1'b0;
    rgb = 3'b010;
    tick(3);
    check_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0);

    // Basic cycle: press held from cycle 0
    res = 1'b0;
    ped_btn = 1'b1;
    tick(6);
    check("press_edge6_btn", btn, 1'b0);
    tick(1);
    check("press_edge7_btn", btn, 1'b1);
    ped_btn = 1'b0;
    tick(2);
    check_outs("wait_red", 1'b1, 1'b0, 1'b1, 1'b0);
    rgb = 3'b100;
    tick(1);
    check_outs("walk_first", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(15);
    check_outs("walk_last", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check("flash_walk", walk, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("flash_dw%0d", i), dont_walk, flash_pat[i]);
      tick(1);
    end
    check_outs("clear", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    check_outs("clear_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    rgb = 3'b010;
    tick(1);
    rgb = 3'b100;
    tick(3);
    check_outs("idle_after_clear", 1'b0, 1'b0, 1'b1, 1'b0);
    rgb = 3'b010;

    // Bounce: toggling every 2 cycles never settles long enough
    for (int i = 0; i < 10; i++) begin
      ped_btn = ~ped_btn;
      tick(2);
      check($sformatf("bounce%0d_btn", i), btn, 1'b0);
    end
    ped_btn = 1'b0;
    tick(10);
    check("bounce_settled_btn", btn, 1'b0);

    // Abort at WALK cycle 5
    ped_btn = 1'b1;
    tick(7);
    check("abort_req_btn", btn, 1'b1);
    ped_btn = 1'b0;
    tick(1);
    rgb = 3'b100;
    tick(1);
    check("abort_walk1", walk, 1'b1);
    tick(4);
    check("abort_walk5", walk, 1'b1);
    rgb = 3'b110;
    tick(1);
    check_outs("abort", 1'b0, 1'b0, 1'b1, 1'b1);
    rgb = 3'b010;
    tick(5);
    check("fault_sticky", fault, 1'b1);

    // Re-request during FLASH leads straight from CLEAR to WAIT_RED
    ped_btn = 1'b1;
    tick(7);
    check("rereq_btn", btn, 1'b1);
    ped_btn = 1'b0;
    tick(1);
    rgb = 3'b100;
    tick(1);
    check("rereq_walk", walk, 1'b1);
    tick(16);
    check_outs("rereq_flash0", 1'b0, 1'b0, 1'b0, 1'b1);
    ped_btn = 1'b1;
    tick(7);
    check("flash_press_btn", btn, 1'b1);
    ped_btn = 1'b0;
    tick(1);
    check_outs("rereq_clear", 1'b1, 1'b0, 1'b1, 1'b1);
    rgb = 3'b010;
    tick(1);
    check("rereq_wait_btn", btn, 1'b1);
    rgb = 3'b100;
    tick(1);
    check_outs("rereq_walk_direct", 1'b0, 1'b1, 1'b0, 1'b1);

    // Press during WALK is ignored
    ped_btn = 1'b1;
    tick(7);
    check("walk_press_btn", btn, 1'b0);
    check("walk_press_walk", walk, 1'b1);
    ped_btn = 1'b0;
    tick(9);
    check("walk_press_flash", walk, 1'b0);
    tick(8);
    check_outs("walk_press_clear", 1'b0, 1'b0, 1'b1, 1'b1);
    rgb = 3'b010;
    tick(1);
    rgb = 3'b100;
    tick(3);
    check_outs("walk_press_idle", 1'b0, 1'b0, 1'b1, 1'b1);
    rgb = 3'b010;
    tick(8);

    // Reset at WALK cycle 3
    ped_btn = 1'b1;
    tick(7);
    check("rst_req_btn", btn, 1'b1);
    ped_btn = 1'b0;
    tick(1);
    rgb = 3'b100;
    tick(3);
    check("rst_walk3", walk, 1'b1);
    res = 1'b1;
    tick(1);
    check_outs("rst_mid_walk", 1'b0, 1'b0, 1'b1, 1'b0);
    res = 1'b0;
    tick(4);
    check_outs("rst_after", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
